// File: rtl/srff_pkg.sv
// Shared definitions for the SR flip-flop bank: conflict-mode codes and the
// single-bit next-state rule used by every channel.
package srff_pkg;

  localparam logic [1:0] CONFLICT_HOLD   = 2'd0;
  localparam logic [1:0] CONFLICT_SET    = 2'd1;
  localparam logic [1:0] CONFLICT_RST    = 2'd2;
  localparam logic [1:0] CONFLICT_TOGGLE = 2'd3;

  // Next state of one SR bit given current state, set, reset and the S=R=1 policy.
  function automatic logic sr_next(input logic       q,
                                   input logic       s,
                                   input logic       r,
                                   input logic [1:0] mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (mode)
          CONFLICT_HOLD: nxt = q;
          CONFLICT_SET:  nxt = 1'b1;
          CONFLICT_RST:  nxt = 1'b0;
          default:       nxt = ~q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/srff_cell.sv
// One clocked SR flip-flop channel with parallel load, enable, registered
// rise/fall pulses and a combinational qualified-conflict flag.
module srff_cell
  import srff_pkg::*;
#(
  parameter int CONFLICT_MODE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  input  logic load_val,
  input  logic S,
  input  logic R,
  output logic q,
  output logic q_rise,
  output logic q_fall,
  output logic conflict
);

  localparam logic [1:0] MODE = 2'(CONFLICT_MODE);

  logic q_q, q_d;
  logic rise_q, fall_q;

  // Next state: load beats enable; with enable off the bit simply holds.
  always_comb begin
    q_d      = q_q;
    conflict = en & ~load & S & R;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = sr_next(q_q, S, R, MODE);
    end
  end

  // State and edge-pulse registers; pulses compare old and new state of the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rise_q <= ~q_q & q_d;
      fall_q <= q_q & ~q_d;
    end
  end

  assign q      = q_q;
  assign q_rise = rise_q;
  assign q_fall = fall_q;

endmodule

// File: rtl/srff_bank.sv
// WIDTH-channel SR flip-flop bank with shared enable/load, per-channel sticky
// conflict flags and a saturating count of cycles that saw any conflict.
module srff_bank
  import srff_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int CONFLICT_MODE = 0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [WIDTH-1:0] conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] conflict_vec;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_conflict;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    srff_cell #(
      .CONFLICT_MODE(CONFLICT_MODE)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .load     (load),
      .load_val (load_val[i]),
      .S        (S[i]),
      .R        (R[i]),
      .q        (q[i]),
      .q_rise   (q_rise[i]),
      .q_fall   (q_fall[i]),
      .conflict (conflict_vec[i])
    );
  end

  assign any_conflict = |conflict_vec;

  // Status update: a conflict arriving with a clear wins, so the clear only
  // drops history, never the event of the current cycle.
  always_comb begin
    sticky_d = sticky_q | conflict_vec;
    cnt_d    = cnt_q;
    if (conflict_clr) begin
      sticky_d = conflict_vec;
      cnt_d    = any_conflict ? CNT_W'(1) : '0;
    end else if (any_conflict && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign conflict_sticky = sticky_q;
  assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_srff_bank.sv
// Bench for srff_bank: four instances (one per conflict mode) share stimulus.
// Mode 0 uses an 8-bit counter, the others a 3-bit counter to reach saturation.
module tb_srff_bank;
  import srff_pkg::*;

  logic       clk = 1'b0;
  logic       reset, en, load, conflict_clr;
  logic [7:0] load_val, S, R;

  logic [7:0] q_w[4], rise_w[4], fall_w[4], st_w[4], cnt_w[4];
  logic [7:0] cnt0;
  logic [2:0] cnt1, cnt2, cnt3;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  srff_bank #(.WIDTH(8), .CONFLICT_MODE(0), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .S(S), .R(R),
    .conflict_clr(conflict_clr), .q(q_w[0]), .q_rise(rise_w[0]), .q_fall(fall_w[0]),
    .conflict_sticky(st_w[0]), .conflict_cnt(cnt0));
  srff_bank #(.WIDTH(8), .CONFLICT_MODE(1), .CNT_W(3)) u1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .S(S), .R(R),
    .conflict_clr(conflict_clr), .q(q_w[1]), .q_rise(rise_w[1]), .q_fall(fall_w[1]),
    .conflict_sticky(st_w[1]), .conflict_cnt(cnt1));
  srff_bank #(.WIDTH(8), .CONFLICT_MODE(2), .CNT_W(3)) u2 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .S(S), .R(R),
    .conflict_clr(conflict_clr), .q(q_w[2]), .q_rise(rise_w[2]), .q_fall(fall_w[2]),
    .conflict_sticky(st_w[2]), .conflict_cnt(cnt2));
  srff_bank #(.WIDTH(8), .CONFLICT_MODE(3), .CNT_W(3)) u3 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .S(S), .R(R),
    .conflict_clr(conflict_clr), .q(q_w[3]), .q_rise(rise_w[3]), .q_fall(fall_w[3]),
    .conflict_sticky(st_w[3]), .conflict_cnt(cnt3));

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = {5'd0, cnt1};
  assign cnt_w[2] = {5'd0, cnt2};
  assign cnt_w[3] = {5'd0, cnt3};

  typedef struct {
    logic [3:0][7:0] q, rise, fall, st, cnt;
  } exp_t;

  typedef struct {
    logic       rst, en, load, clr;
    logic [7:0] lv, s, r;
    logic [7:0] eq0, eq1, eq2, eq3, erise0, est, ecnt;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[9];

  logic [7:0] mq[4], mst[4];
  int         mcnt[4];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    nchk++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
    end
  endtask

  // Drive one edge: model predicts, expectation is queued, then popped and compared after the edge.
  task automatic drive(input logic rst_v, input logic en_v, input logic load_v, input logic clr_v,
                       input logic [7:0] lv, input logic [7:0] s_v, input logic [7:0] r_v);
    exp_t e, got;
    logic [7:0] qn, conf;
    int cmax;
    reset = rst_v; en = en_v; load = load_v; conflict_clr = clr_v;
    load_val = lv; S = s_v; R = r_v;
    for (int d = 0; d < 4; d++) begin
      cmax = (d == 0) ? 255 : 7;
      if (!rst_v) begin
        mq[d] = 8'h00; mst[d] = 8'h00; mcnt[d] = 0;
        e.q[d] = 8'h00; e.rise[d] = 8'h00; e.fall[d] = 8'h00;
      end else begin
        if (load_v) qn = lv;
        else if (en_v) for (int i = 0; i < 8; i++) qn[i] = sr_next(mq[d][i], s_v[i], r_v[i], 2'(d));
        else qn = mq[d];
        conf = (en_v && !load_v) ? (s_v & r_v) : 8'h00;
        e.rise[d] = qn & ~mq[d];
        e.fall[d] = ~qn & mq[d];
        mq[d] = qn;
        if (clr_v) begin
          mst[d] = conf;
          mcnt[d] = (conf != 0) ? 1 : 0;
        end else begin
          mst[d] = mst[d] | conf;
          if (conf != 0 && mcnt[d] < cmax) mcnt[d]++;
        end
        e.q[d] = qn;
      end
      e.st[d] = mst[d];
      e.cnt[d] = 8'(mcnt[d]);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("sb_q_u%0d", d), q_w[d], got.q[d]);
      chk($sformatf("sb_rise_u%0d", d), rise_w[d], got.rise[d]);
      chk($sformatf("sb_fall_u%0d", d), fall_w[d], got.fall[d]);
      chk($sformatf("sb_sticky_u%0d", d), st_w[d], got.st[d]);
      chk($sformatf("sb_cnt_u%0d", d), cnt_w[d], got.cnt[d]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; en = 1'b0; load = 1'b0; conflict_clr = 1'b0;
    load_val = 8'h00; S = 8'h00; R = 8'h00;
    for (int d = 0; d < 4; d++) begin mq[d] = 8'h00; mst[d] = 8'h00; mcnt[d] = 0; end

    //         rst en ld clr lv     s      r      q0     q1     q2     q3     rise0  sticky cnt
    tbl[0] = '{1'b0,1'b1,1'b0,1'b0,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    tbl[1] = '{1'b0,1'b1,1'b0,1'b0,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    tbl[2] = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h01,8'h00,8'h01,8'h01,8'h01,8'h01,8'h01,8'h00,8'h00};
    tbl[3] = '{1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,8'h00,8'h01,8'h01,8'h01,8'h01,8'h00,8'h00,8'h00};
    tbl[4] = '{1'b1,1'b0,1'b1,1'b0,8'h0F,8'h00,8'h00,8'h0F,8'h0F,8'h0F,8'h0F,8'h0E,8'h00,8'h00};
    tbl[5] = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'hFF,8'hFF,8'h0F,8'hFF,8'h00,8'hF0,8'h00,8'hFF,8'h01};
    tbl[6] = '{1'b1,1'b1,1'b1,1'b0,8'hA5,8'hFF,8'h00,8'hA5,8'hA5,8'hA5,8'hA5,8'hA0,8'hFF,8'h01};
    tbl[7] = '{1'b1,1'b0,1'b0,1'b0,8'h00,8'hFF,8'hFF,8'hA5,8'hA5,8'hA5,8'hA5,8'h00,8'hFF,8'h01};
    tbl[8] = '{1'b1,1'b0,1'b0,1'b1,8'h00,8'h00,8'h00,8'hA5,8'hA5,8'hA5,8'hA5,8'h00,8'h00,8'h00};

    // Reset, set, load, per-mode conflict, priority and plain clear.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].clr, tbl[i].lv, tbl[i].s, tbl[i].r);
      chk($sformatf("tbl%0d_q_u0", i), q_w[0], tbl[i].eq0);
      chk($sformatf("tbl%0d_q_u1", i), q_w[1], tbl[i].eq1);
      chk($sformatf("tbl%0d_q_u2", i), q_w[2], tbl[i].eq2);
      chk($sformatf("tbl%0d_q_u3", i), q_w[3], tbl[i].eq3);
      chk($sformatf("tbl%0d_rise_u0", i), rise_w[0], tbl[i].erise0);
      chk($sformatf("tbl%0d_sticky_u3", i), st_w[3], tbl[i].est);
      chk($sformatf("tbl%0d_cnt_u1", i), cnt_w[1], tbl[i].ecnt);
    end

    // Counter saturation on channel 2.
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 8'h04);
      chk($sformatf("sat%0d_cnt_u1", k), cnt_w[1], 8'((k > 7) ? 7 : k));
      chk($sformatf("sat%0d_cnt_u0", k), cnt_w[0], 8'(k));
    end
    chk("sat_sticky_u2", st_w[2], 8'h04);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    chk("satclr_cnt_u3", cnt_w[3], 8'h00);
    chk("satclr_sticky_u3", st_w[3], 8'h00);

    // Clear colliding with a new conflict.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h01);
    chk("coll_pre_sticky_u0", st_w[0], 8'h01);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h10, 8'h10);
    chk("coll_sticky_u0", st_w[0], 8'h10);
    chk("coll_cnt_u0", cnt_w[0], 8'h01);
    chk("coll_cnt_u2", cnt_w[2], 8'h01);

    // Reset in the middle of sustained toggling.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF);
    chk("tog_q_u3", q_w[3], 8'hFF);
    chk("tog_rise_u3", rise_w[3], 8'hFF);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF);
    chk("midrst_q_u3", q_w[3], 8'h00);
    chk("midrst_rise_u3", rise_w[3], 8'h00);
    chk("midrst_fall_u3", fall_w[3], 8'h00);
    chk("midrst_cnt_u3", cnt_w[3], 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF);
    chk("post1_q_u3", q_w[3], 8'hFF);
    chk("post1_rise_u3", rise_w[3], 8'hFF);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF);
    chk("post2_q_u3", q_w[3], 8'h00);
    chk("post2_rise_u3", rise_w[3], 8'h00);
    chk("post2_fall_u3", fall_w[3], 8'hFF);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
